// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the fetch-stage front end.
package pc_fetch_unit_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read bus: one request channel, one response channel.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC register, single-outstanding imem read, holding register to decode.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int            XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_en,
  input  logic [XLEN-1:0]   redirect_pc,
  pc_fetch_unit_if.master   imem,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_instr,
  input  logic              if_ready,
  output logic              pc_misaligned
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;
  logic            drop, drop_nxt;
  logic            run;
  logic            if_valid_nxt;
  logic [XLEN-1:0] if_pc_nxt, if_instr_nxt;
  logic [XLEN-1:0] tgt;
  logic            accept, handoff;

  // run gates the request so nothing is issued while reset is held
  assign imem.imem_req_valid = run && (state == S_REQ);
  assign imem.imem_req_addr  = req_addr;

  assign tgt     = {redirect_pc[XLEN-1:2], 2'b00};
  assign accept  = imem.imem_req_valid && imem.imem_req_ready;
  assign handoff = if_valid && if_ready;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    drop_nxt     = drop;
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_instr_nxt = if_instr;
    case (state)
      S_REQ: begin
        if (redirect_en) begin
          pc_nxt = tgt;
          if (accept) begin
            drop_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end else if (imem.imem_req_valid) begin
            // offered request cannot be withdrawn; let it finish and discard it
            drop_nxt = 1'b1;
          end else begin
            req_addr_nxt = tgt;
          end
        end else if (accept) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (redirect_en) begin
            pc_nxt       = tgt;
            req_addr_nxt = tgt;
            drop_nxt     = 1'b0;
            state_nxt    = S_REQ;
          end else if (drop) begin
            req_addr_nxt = pc;
            drop_nxt     = 1'b0;
            state_nxt    = S_REQ;
          end else begin
            if_valid_nxt = 1'b1;
            if_pc_nxt    = pc;
            if_instr_nxt = imem.imem_rsp_data;
            state_nxt    = S_HOLD;
          end
        end else if (redirect_en) begin
          pc_nxt   = tgt;
          drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          if_valid_nxt = 1'b0;
          pc_nxt       = tgt;
          req_addr_nxt = tgt;
          state_nxt    = S_REQ;
        end else if (handoff) begin
          if_valid_nxt = 1'b0;
          pc_nxt       = pc + XLEN'(4);
          req_addr_nxt = pc + XLEN'(4);
          state_nxt    = S_REQ;
        end
      end
      default: begin
        state_nxt    = S_REQ;
        if_valid_nxt = 1'b0;
        req_addr_nxt = pc;
        drop_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      drop          <= 1'b0;
      run           <= 1'b0;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_instr      <= '0;
      pc_misaligned <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      req_addr      <= req_addr_nxt;
      drop          <= drop_nxt;
      run           <= 1'b1;
      if_valid      <= if_valid_nxt;
      if_pc         <= if_pc_nxt;
      if_instr      <= if_instr_nxt;
      pc_misaligned <= redirect_en && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small latency-programmable imem responder.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        pc_misaligned;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem(bus), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // imem responder: rsp_valid mem_lat+1 cycles after accept
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; cnt <= 0; paddr <= '0;
      bus.imem_rsp_valid <= 1'b0; bus.imem_rsp_data <= '0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        paddr <= bus.imem_req_addr;
        cnt   <= mem_lat;
        if (mem_lat == 0) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(bus.imem_req_addr);
          pend <= 1'b0;
        end else pend <= 1'b1;
      end else if (pend) begin
        if (cnt <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(paddr);
          pend <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic wait_req(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.imem_req_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_if(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (if_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; redirect_en = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 0", bus.imem_req_addr); end
    checks++; if ({if_valid, pc_misaligned} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {if_valid, pc_misaligned}); end
    checks++; if ({if_pc, if_instr} !== 64'h0) begin errors++; $display("FAIL rst_if_data got %h exp 0", {if_pc, if_instr}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got v=%b a=%h exp v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_sequential;
    bit ok;
    int t0 = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(20, ok);
      checks++; if (!ok || bus.imem_req_addr !== 32'(k*4)) begin
        errors++; $display("FAIL seq_req%0d got ok=%b a=%h exp a=%h", k, ok, bus.imem_req_addr, 32'(k*4)); end
      wait_if(20, ok);
      checks++; if (!ok || if_pc !== 32'(k*4) || if_instr !== mem_word(32'(k*4))) begin
        errors++; $display("FAIL seq_if%0d got ok=%b pc=%h ins=%h exp pc=%h", k, ok, if_pc, if_instr, 32'(k*4)); end
      if (k > 0) begin
        checks++; if (cyc - t0 != 3) begin errors++; $display("FAIL seq_rate got %0d exp 3", cyc - t0); end
      end
      t0 = cyc;
    end
    @(negedge clk);
    if_ready = 1'b0;
  endtask

  task automatic test_stall;
    bit ok;
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'hC) begin errors++; $display("FAIL stall_if got ok=%b pc=%h exp c", ok, if_pc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem_word(32'hC) || bus.imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h req=%b", i, if_valid, if_pc, if_instr, bus.imem_req_valid); end
    end
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h10) begin
      errors++; $display("FAIL stall_release got v=%b req=%b a=%h exp 0 1 10", if_valid, bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    mem_lat = 2;
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0; mem_lat = 0;
    checks++; if (bus.imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rw_wait got req=%b v=%b exp 0 0", bus.imem_req_valid, if_valid); end
    wait_req(20, ok);
    checks++; if (!ok || bus.imem_req_addr !== 32'h100) begin errors++; $display("FAIL rw_req got ok=%b a=%h exp 100", ok, bus.imem_req_addr); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
      errors++; $display("FAIL rw_if got ok=%b pc=%h ins=%h exp pc=100", ok, if_pc, if_instr); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h104) begin
      errors++; $display("FAIL b2b_req got v=%b a=%h exp 104", bus.imem_req_valid, bus.imem_req_addr); end
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_en = 1'b0;
    checks++; if (if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
      errors++; $display("FAIL b2b_rsp_redir got v=%b req=%b a=%h exp 0 1 200", if_valid, bus.imem_req_valid, bus.imem_req_addr); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h200) begin errors++; $display("FAIL b2b_if got ok=%b pc=%h exp 200", ok, if_pc); end
    redirect_en = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_en = 1'b0;
    checks++; if (if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h300) begin
      errors++; $display("FAIL b2b_hold_redir got v=%b req=%b a=%h exp 0 1 300", if_valid, bus.imem_req_valid, bus.imem_req_addr); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h300) begin errors++; $display("FAIL b2b_if2 got ok=%b pc=%h exp 300", ok, if_pc); end
  endtask

  task automatic test_misalign_wrap;
    bit ok;
    redirect_en = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_en = 1'b0;
    checks++; if (pc_misaligned !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL mis_pulse got m=%b a=%h exp 1 100", pc_misaligned, bus.imem_req_addr); end
    @(negedge clk);
    checks++; if (pc_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", pc_misaligned); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h100) begin errors++; $display("FAIL mis_if got ok=%b pc=%h exp 100", ok, if_pc); end
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    checks++; if (pc_misaligned !== 1'b0) begin errors++; $display("FAIL wrap_nomis got %b exp 0", pc_misaligned); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got ok=%b pc=%h exp fffffffc", ok, if_pc); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL wrap_zero got ok=%b pc=%h ins=%h exp pc=0", ok, if_pc, if_instr); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    mem_lat = 3;
    @(negedge clk);
    wait_req(20, ok);
    @(negedge clk);
    checks++; if (!ok || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_inwait got ok=%b req=%b exp 0", ok, bus.imem_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL rm_async got req=%b a=%h v=%b pc=%h ins=%h exp all 0", bus.imem_req_valid, bus.imem_req_addr, if_valid, if_pc, if_instr); end
    mem_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL rm_restart got v=%b a=%h exp 1 0", bus.imem_req_valid, bus.imem_req_addr); end
    wait_if(20, ok);
    checks++; if (!ok || if_pc !== 32'h0) begin errors++; $display("FAIL rm_if got ok=%b pc=%h exp 0", ok, if_pc); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_wait;
    test_back_to_back;
    test_misalign_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
